uop_queue: RTL and testbench
============================

// Module: uop_queue
// PURPOSE
// Micro-op buffer between decode_unit and the execute stage. Accepts one decoded bundle
// (1..3 uops) per feed_ack, stores the uops in issue order, and presents them one per
// cycle to execute via a valid/ready handshake. Drives decode's feed_req from free space.
// A flush (branch redirect / pc invalidate) discards every buffered uop.
// PARAMETERS
// DEPTH   8   Entry count. Power of two, >= 4.
// PTR_W   3   log2(DEPTH). Pointer width.
// PORTS
// clk         in   1      clock
// a_rst       in   1      reset, asynchronous, active-low
// flush       in   1      synchronous discard of all entries
// feed_ack    in   1      decode issued a bundle this cycle
// uop_count   in   2      bundle size code: 0 -> 1 uop, 1 -> 2 uops, 2/3 -> 3 uops
// uop_0       in   20     final uop (ALU/store step), always present
// uop_1       in   20     address/load uop, present if uop_count >= 1
// uop_2       in   20     index-fetch uop, present if uop_count >= 2
// feed_req    out  1      space for a full 3-uop bundle exists
// uop_out     out  20     head uop to execute
// uop_last    out  1      head uop is the last uop of its instruction
// uop_valid   out  1      head entry valid
// exec_ready  in   1      execute consumes the head this cycle if uop_valid
// insn_done   out  1      pulse: the last uop of an instruction was popped this cycle
// empty       out  1      occupancy == 0
// occupancy   out  PTR_W+1  current entry count, 0..DEPTH
// BEHAVIOUR
// - Storage: DEPTH x 21 bits {last, uop}. Circular, wr_ptr/rd_ptr wrap mod DEPTH.
// - Reset (a_rst low): wr_ptr=rd_ptr=0, occupancy=0; outputs: uop_valid=0, uop_last=0,
//   uop_out=0, insn_done=0, empty=1, feed_req=1. Array contents not reset.
// - Push, when feed_ack & ~flush: n = (uop_count==0)?1 : (uop_count==1)?2 : 3.
//   Written in order at wr_ptr, wr_ptr+1, wr_ptr+2:
//   n=3: uop_2, uop_1, uop_0; n=2: uop_1, uop_0; n=1: uop_0.
//   last=1 only on the uop_0 entry. wr_ptr += n.
// - feed_req = (DEPTH - occupancy) >= 3, combinational from registered occupancy.
//   feed_ack while feed_req=0 is a protocol error: ignored (no write); bench flags it.
// - Pop: uop_valid = (occupancy != 0). When uop_valid & exec_ready & ~flush: rd_ptr += 1.
// - uop_out/uop_last = head entry when uop_valid, else 0. Zero-cycle bypass not provided:
//   a pushed uop is visible at uop_out no earlier than the cycle after feed_ack.
// - insn_done = uop_valid & exec_ready & uop_last & ~flush (combinational).
// - occupancy_next = occupancy + n_push - pop; simultaneous push and pop both take effect.
// - Flush: wr_ptr=rd_ptr=0, occupancy=0 next cycle; overrides push and pop in the same
//   cycle (bundle acked in that cycle is dropped, no pop, insn_done=0).
// - Full: occupancy==DEPTH -> feed_req=0, pops continue normally.
// - Empty: exec_ready ignored, pointers hold.
// - a_rst asserted mid-operation: immediate return to reset state, buffered uops lost.
// TESTING
// 1. Reset, push uop_count=0 uop_0=20'hABCDE -> next cycle uop_valid=1, uop_out=ABCDE,
//    uop_last=1; exec_ready=1 -> insn_done=1, then empty=1, occupancy=0.
// 2. Push uop_count=2 (uop_2=2, uop_1=1, uop_0=0), exec_ready=1 -> uop_out sequence 2,1,0
//    on three consecutive cycles, uop_last=0,0,1, insn_done only on third.
// 3. DEPTH=8, exec_ready=0, push 3-uop bundles: after 2 bundles occupancy=6, feed_req=0;
//    one pop -> occupancy=5, feed_req=1.
// 4. Occupancy=4 with feed_ack (uop_count=1) and exec_ready=1 and flush=1 same cycle ->
//    next cycle occupancy=0, empty=1, uop_valid=0, insn_done=0 in flush cycle.
// 5. Wrap: repeated 3-uop pushes with continuous pops over >=20 uops -> output order and
//    uop_last pattern match push order across pointer wrap; occupancy never exceeds 8.
// 6. a_rst pulsed low with occupancy=5 -> outputs immediately at reset values, feed_req=1.

Source files
------------

// File: rtl/uop_queue.sv
// uop_queue: circular micro-op buffer between decode and execute.
// Stores {last, uop} entries in issue order. Decode may push up to three uops
// per feed_ack, and execute pops one uop per handshake.
//
// Handshake semantics: uop_valid is high whenever the buffer holds an entry.
// The head is consumed on a clock edge where uop_valid & exec_ready & ~flush
// are all high. When uop_valid is low, exec_ready is ignored. On the feed side,
// feed_req advertises room for a full 3-uop bundle. A feed_ack that arrives
// while feed_req is low is dropped.
module uop_queue #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             a_rst,
  input  logic             flush,
  input  logic             feed_ack,
  input  logic [1:0]       uop_count,
  input  logic [19:0]      uop_0,
  input  logic [19:0]      uop_1,
  input  logic [19:0]      uop_2,
  output logic             feed_req,
  output logic [19:0]      uop_out,
  output logic             uop_last,
  output logic             uop_valid,
  input  logic             exec_ready,
  output logic             insn_done,
  output logic             empty,
  output logic [PTR_W:0]   occupancy
);

  typedef logic [20:0] entry_t;

  localparam logic [PTR_W:0] DEPTH_W    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] BUNDLE_MAX = (PTR_W+1)'(3);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   occ_q, occ_d;
  logic [1:0]       n_push;
  logic             push;
  logic             pop;
  entry_t           head;

  // Free-space request and occupancy come straight from the registered count.
  assign feed_req  = (DEPTH_W - occ_q) >= BUNDLE_MAX;
  assign occupancy = occ_q;

  // Decode the bundle size, qualify push/pop, and drive the head outputs.
  always_comb begin
    case (uop_count)
      2'd0:    n_push = 2'd1;
      2'd1:    n_push = 2'd2;
      default: n_push = 2'd3;
    endcase
    push      = feed_ack & ~flush & feed_req;
    uop_valid = (occ_q != '0);
    empty     = (occ_q == '0);
    head      = mem_q[rd_ptr_q];
    pop       = uop_valid & exec_ready & ~flush;
    uop_out   = uop_valid ? head[19:0] : 20'd0;
    uop_last  = uop_valid & head[20];
    insn_done = pop & head[20];
  end

  // Next-state logic: the bundle is written oldest-first (index-fetch, then
  // address, then the final uop). A flush overrides both push and pop.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        case (n_push)
          2'd3: begin
            mem_d[wr_ptr_q]             = {1'b0, uop_2};
            mem_d[wr_ptr_q + PTR_W'(1)] = {1'b0, uop_1};
            mem_d[wr_ptr_q + PTR_W'(2)] = {1'b1, uop_0};
          end
          2'd2: begin
            mem_d[wr_ptr_q]             = {1'b0, uop_1};
            mem_d[wr_ptr_q + PTR_W'(1)] = {1'b1, uop_0};
          end
          default: begin
            mem_d[wr_ptr_q]             = {1'b1, uop_0};
          end
        endcase
        wr_ptr_d = wr_ptr_q + PTR_W'(n_push);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      occ_d = occ_q + (push ? (PTR_W+1)'(n_push) : '0) - (PTR_W+1)'(pop);
    end
  end

  // Pointer and occupancy registers, cleared immediately by a_rst.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage. It has no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: randomized and directed stimulus against a queue-based model.
// The driver appends accepted uops to exp_q, and the monitor pops and compares
// them whenever execute consumes the head.
module tb_uop_queue;

  localparam int DEPTH = 8;

  logic        clk;
  logic        a_rst;
  logic        flush;
  logic        feed_ack;
  logic [1:0]  uop_count;
  logic [19:0] uop_0, uop_1, uop_2;
  logic        feed_req;
  logic [19:0] uop_out;
  logic        uop_last;
  logic        uop_valid;
  logic        exec_ready;
  logic        insn_done;
  logic        empty;
  logic [3:0]  occupancy;

  logic [20:0] exp_q[$];
  int          n_cmp;
  int          n_err;
  int          n_proto;

  uop_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
    .clk        (clk),
    .a_rst      (a_rst),
    .flush      (flush),
    .feed_ack   (feed_ack),
    .uop_count  (uop_count),
    .uop_0      (uop_0),
    .uop_1      (uop_1),
    .uop_2      (uop_2),
    .feed_req   (feed_req),
    .uop_out    (uop_out),
    .uop_last   (uop_last),
    .uop_valid  (uop_valid),
    .exec_ready (exec_ready),
    .insn_done  (insn_done),
    .empty      (empty),
    .occupancy  (occupancy)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus. The model is updated at the clock edge: a flush
  // empties it, and an accepted bundle appends its uops oldest-first.
  task automatic drive(input logic fa, input logic [1:0] cnt, input logic [19:0] u0,
                       input logic [19:0] u1, input logic [19:0] u2,
                       input logic er, input logic fl);
    int occ0;
    occ0       = exp_q.size();
    feed_ack   = fa;
    uop_count  = cnt;
    uop_0      = u0;
    uop_1      = u1;
    uop_2      = u2;
    exec_ready = er;
    flush      = fl;
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else if (fa) begin
      if (DEPTH - occ0 >= 3) begin
        if (cnt >= 2'd2) exp_q.push_back({1'b0, u2});
        if (cnt >= 2'd1) exp_q.push_back({1'b0, u1});
        exp_q.push_back({1'b1, u0});
      end else begin
        n_proto++;
        $display("note: feed_ack while feed_req low at %0t, bundle dropped", $time);
      end
    end
    #1;
  endtask

  task automatic idle(input logic er);
    drive(1'b0, 2'd0, 20'd0, 20'd0, 20'd0, er, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},     {31'd0, uop_valid}, 32'd0);
    check({tag, "_last"},      {31'd0, uop_last},  32'd0);
    check({tag, "_uop_out"},   {12'd0, uop_out},   32'd0);
    check({tag, "_insn_done"}, {31'd0, insn_done}, 32'd0);
    check({tag, "_empty"},     {31'd0, empty},     32'd1);
    check({tag, "_feed_req"},  {31'd0, feed_req},  32'd1);
    check({tag, "_occupancy"}, {28'd0, occupancy}, 32'd0);
  endtask

  // Monitor: compares status against the model and pops on every consumed head.
  always @(negedge clk) begin : monitor
    int          sz;
    logic [20:0] e;
    if (a_rst) begin
      sz = exp_q.size();
      check("occupancy", {28'd0, occupancy}, sz);
      check("empty",     {31'd0, empty},     (sz == 0) ? 32'd1 : 32'd0);
      check("feed_req",  {31'd0, feed_req},  (DEPTH - sz >= 3) ? 32'd1 : 32'd0);
      check("uop_valid", {31'd0, uop_valid}, (sz != 0) ? 32'd1 : 32'd0);
      if (sz != 0 && exec_ready && !flush) begin
        e = exp_q.pop_front();
        check("uop_out",   {12'd0, uop_out},   {12'd0, e[19:0]});
        check("uop_last",  {31'd0, uop_last},  {31'd0, e[20]});
        check("insn_done", {31'd0, insn_done}, {31'd0, e[20]});
      end else begin
        check("insn_done_idle", {31'd0, insn_done}, 32'd0);
        if (sz == 0) begin
          check("uop_out_empty",  {12'd0, uop_out},  32'd0);
          check("uop_last_empty", {31'd0, uop_last}, 32'd0);
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    n_cmp      = 0;
    n_err      = 0;
    n_proto    = 0;
    a_rst      = 1'b0;
    flush      = 1'b0;
    feed_ack   = 1'b0;
    uop_count  = 2'd0;
    uop_0      = 20'd0;
    uop_1      = 20'd0;
    uop_2      = 20'd0;
    exec_ready = 1'b0;
    #2;
    check_reset_outputs("reset");
    #10 a_rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-uop bundle, then consume it.
    drive(1'b1, 2'd0, 20'hABCDE, 20'd0, 20'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Three-uop bundle drained back-to-back.
    drive(1'b1, 2'd2, 20'd0, 20'd1, 20'd2, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);

    // Fill to 6 so feed_req drops, then one pop reopens it.
    drive(1'b1, 2'd2, 20'h00003, 20'h00013, 20'h00023, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 20'h00004, 20'h00014, 20'h00024, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b1);

    // Flush at occupancy 4 together with a push and a pop request.
    drive(1'b1, 2'd1, 20'h11111, 20'h22222, 20'd0, 1'b1, 1'b1);
    idle(1'b0);

    // Wrap: 3-uop pushes whenever there is room, continuous pops.
    for (int i = 0; i < 30; i++) begin
      drive((DEPTH - exp_q.size()) >= 3, 2'd2, 20'($urandom), 20'($urandom),
            20'($urandom), 1'b1, 1'b0);
    end
    for (int i = 0; i < 8; i++) idle(1'b1);

    // Randomized traffic, including occasional flushes and dropped bundles.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 70, 2'($urandom_range(0, 3)), 20'($urandom),
            20'($urandom), 20'($urandom), $urandom_range(0, 99) < 60,
            $urandom_range(0, 99) < 3);
    end

    // Asynchronous reset with occupancy 5.
    drive(1'b0, 2'd0, 20'd0, 20'd0, 20'd0, 1'b0, 1'b1);
    drive(1'b1, 2'd2, 20'h0000A, 20'h0000B, 20'h0000C, 1'b0, 1'b0);
    drive(1'b1, 2'd1, 20'h0000D, 20'h0000E, 20'd0, 1'b0, 1'b0);
    check("pre_reset_occupancy", {28'd0, occupancy}, 32'd5);
    feed_ack   = 1'b0;
    exec_ready = 1'b0;
    #2;
    a_rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete();
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    drive(1'b1, 2'd0, 20'h55555, 20'd0, 20'd0, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    check("final_model_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
